systolic_array_ctrl: RTL and testbench

//  Sequencer for one ROWS x COLS weight-stationary PE grid. PE partial sums are registered
//  and move right; activations pass down each column combinationally. Per job, the block

---
 rtl/systolic_array_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_systolic_array_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/systolic_array_ctrl.sv
// Sequencer for a weight-stationary ROWS x COLS PE grid: loads every PE weight,
// streams column-skewed activation vectors, then flags each row result at the right edge.
module systolic_array_ctrl #(
  parameter int ROWS  = 4,
  parameter int COLS  = 4,
  parameter int LEN_W = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic [LEN_W-1:0]              cfg_len,
  output logic                          busy,
  output logic                          done,
  output logic                          w_rd_en,
  output logic [$clog2(ROWS*COLS)-1:0]  w_rd_addr,
  output logic                          w_wr_en,
  output logic [$clog2(ROWS)-1:0]       w_row,
  output logic [$clog2(COLS)-1:0]       w_col,
  output logic [COLS-1:0]               col_en,
  output logic [COLS*LEN_W-1:0]         act_idx,
  output logic                          res_valid,
  output logic [LEN_W-1:0]              res_idx
);

  localparam int AW = $clog2(ROWS*COLS);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int TW = LEN_W + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [RW-1:0]      row_q, row_d;
  logic [CW-1:0]      col_q, col_d;
  logic [TW-1:0]      t_q, t_d;
  logic               w_wr_en_q, w_wr_en_d;
  logic [RW-1:0]      w_row_q, w_row_d;
  logic [CW-1:0]      w_col_q, w_col_d;
  logic [1:0]         res_v_q, res_v_d;
  logic [LEN_W-1:0]   res_idx0_q, res_idx0_d;
  logic [LEN_W-1:0]   res_idx1_q, res_idx1_d;

  logic [TW-1:0]      stream_last_s;
  logic [TW-1:0]      drain_last_s;
  logic               load_last_s;
  logic [COLS-1:0]    col_en_s;
  logic [COLS*LEN_W-1:0] act_idx_s;
  logic [TW-1:0]      diff_s;

  // t is one bit wider than len so len+COLS cannot wrap for the longest job
  assign stream_last_s = {1'b0, len_q} + TW'(COLS) - TW'(2);
  assign drain_last_s  = {1'b0, len_q} + TW'(COLS);
  assign load_last_s   = (row_q == RW'(ROWS-1)) && (col_q == CW'(COLS-1));

  // Next-state and counter logic; abort overrides everything
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    row_d   = row_q;
    col_d   = col_q;
    t_d     = t_q;
    if (abort) begin
      state_d = S_IDLE;
      row_d   = {RW{1'b0}};
      col_d   = {CW{1'b0}};
      t_d     = {TW{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            len_d   = cfg_len;
            state_d = S_LOAD_W;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_LOAD_W: begin
          if (load_last_s) begin
            row_d   = {RW{1'b0}};
            col_d   = {CW{1'b0}};
            t_d     = {TW{1'b0}};
            state_d = (len_q == {LEN_W{1'b0}}) ? S_DONE : S_STREAM;
          end else if (col_q == CW'(COLS-1)) begin
            col_d = {CW{1'b0}};
            row_d = row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
        end
        S_STREAM: begin
          t_d = t_q + TW'(1);
          if (t_q == stream_last_s) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_STREAM;
          end
        end
        S_DRAIN: begin
          if (t_q == drain_last_s) begin
            t_d     = {TW{1'b0}};
            state_d = S_DONE;
          end else begin
            t_d = t_q + TW'(1);
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Column c sees vector t-c, so partial sums from column c-1 meet the matching element
  always_comb begin
    col_en_s  = {COLS{1'b0}};
    act_idx_s = {(COLS*LEN_W){1'b0}};
    diff_s    = {TW{1'b0}};
    for (int c = 0; c < COLS; c++) begin
      diff_s = t_q - TW'(c);
      if ((state_q == S_STREAM) && (t_q >= TW'(c)) && (diff_s < {1'b0, len_q})) begin
        col_en_s[c]                    = 1'b1;
        act_idx_s[c*LEN_W +: LEN_W]    = diff_s[LEN_W-1:0];
      end else begin
        col_en_s[c] = 1'b0;
      end
    end
  end

  // Weight-write strobe trails the read by the buffer latency; results trail the last column by 2
  always_comb begin
    w_wr_en_d  = 1'b0;
    w_row_d    = {RW{1'b0}};
    w_col_d    = {CW{1'b0}};
    res_v_d    = 2'b00;
    res_idx0_d = {LEN_W{1'b0}};
    res_idx1_d = {LEN_W{1'b0}};
    if (abort) begin
      w_wr_en_d = 1'b0;
    end else begin
      w_wr_en_d  = (state_q == S_LOAD_W);
      w_row_d    = w_wr_en_d ? row_q : {RW{1'b0}};
      w_col_d    = w_wr_en_d ? col_q : {CW{1'b0}};
      res_v_d    = {res_v_q[0], col_en_s[COLS-1]};
      res_idx0_d = act_idx_s[(COLS-1)*LEN_W +: LEN_W];
      res_idx1_d = res_idx0_q;
    end
  end

  // State, counters and output pipeline registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      len_q      <= {LEN_W{1'b0}};
      row_q      <= {RW{1'b0}};
      col_q      <= {CW{1'b0}};
      t_q        <= {TW{1'b0}};
      w_wr_en_q  <= 1'b0;
      w_row_q    <= {RW{1'b0}};
      w_col_q    <= {CW{1'b0}};
      res_v_q    <= 2'b00;
      res_idx0_q <= {LEN_W{1'b0}};
      res_idx1_q <= {LEN_W{1'b0}};
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      row_q      <= row_d;
      col_q      <= col_d;
      t_q        <= t_d;
      w_wr_en_q  <= w_wr_en_d;
      w_row_q    <= w_row_d;
      w_col_q    <= w_col_d;
      res_v_q    <= res_v_d;
      res_idx0_q <= res_idx0_d;
      res_idx1_q <= res_idx1_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign w_rd_en   = (state_q == S_LOAD_W);
  assign w_rd_addr = w_rd_en ? (AW'(row_q) * AW'(COLS) + AW'(col_q)) : {AW{1'b0}};
  assign w_wr_en   = w_wr_en_q;
  assign w_row     = w_row_q;
  assign w_col     = w_col_q;
  assign col_en    = col_en_s;
  assign act_idx   = act_idx_s;
  assign res_valid = res_v_q[1];
  assign res_idx   = res_idx1_q;

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Bench for systolic_array_ctrl: table of jobs checked cycle by cycle against a timing
// model, with a result scoreboard filled when each job is started.
module tb_systolic_array_ctrl;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int LEN_W = 8;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [7:0]  cfg_len;
  logic        busy, done, w_rd_en, w_wr_en, res_valid;
  logic [3:0]  w_rd_addr, col_en;
  logic [1:0]  w_row, w_col;
  logic [31:0] act_idx;
  logic [7:0]  res_idx;
  logic [47:0] dut_outs;

  int checks = 0;
  int errors = 0;

  typedef struct { int idx; int cyc; } res_t;
  typedef struct {
    int len; int dup_n; int dup_len; int abort_n; int rst_n; int done_at; int n_res;
  } vec_t;

  res_t sb_q[$];
  vec_t tbl[10];

  always #5 clk = ~clk;

  systolic_array_ctrl #(.ROWS(ROWS), .COLS(COLS), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_len(cfg_len),
    .busy(busy), .done(done), .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr),
    .w_wr_en(w_wr_en), .w_row(w_row), .w_col(w_col), .col_en(col_en),
    .act_idx(act_idx), .res_valid(res_valid), .res_idx(res_idx)
  );

  assign dut_outs = {busy, done, w_rd_en, w_rd_addr, w_wr_en, w_row, w_col, col_en, act_idx};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Expected outputs n cycles after start was sampled, straight from the job timeline
  function automatic logic [47:0] exp_outs(int n, int len, int done_at, bit killed);
    logic bz, dn, rd, wr;
    logic [3:0] addr, cen;
    logic [1:0] row, col;
    logic [31:0] act;
    int t;
    bz = 1'b0; dn = 1'b0; rd = 1'b0; wr = 1'b0;
    addr = 4'd0; cen = 4'd0; row = 2'd0; col = 2'd0; act = 32'd0;
    if (!killed && n >= 1) begin
      bz = (done_at < 0) || (n <= done_at);
      dn = (n == done_at);
      if (n <= 16) begin
        rd = 1'b1;
        addr = 4'(n - 1);
      end
      if (n >= 2 && n <= 17) begin
        wr = 1'b1;
        row = 2'((n - 2) / 4);
        col = 2'((n - 2) % 4);
      end
      t = n - 17;
      for (int c = 0; c < 4; c++) begin
        if (t >= c && (t - c) < len) begin
          cen[c] = 1'b1;
          act[c*8 +: 8] = 8'(t - c);
        end
      end
    end
    return {bz, dn, rd, addr, wr, row, col, cen, act};
  endfunction

  task automatic run_vec(input vec_t v);
    int kill_n, last_n, pulses, dones;
    bit killed, exp_v;
    kill_n = (v.abort_n >= 0) ? v.abort_n : v.rst_n;
    last_n = (v.done_at >= 0) ? v.done_at + 2 : kill_n + 3;
    pulses = 0;
    dones  = 0;
    for (int n = 0; n <= last_n; n++) begin
      @(negedge clk);
      killed = (kill_n >= 0) && (n > kill_n);
      check($sformatf("outs len=%0d n=%0d", v.len, n), 64'(dut_outs),
            64'(exp_outs(n, v.len, v.done_at, killed)));
      exp_v = (sb_q.size() > 0) && (sb_q[0].cyc == n);
      check($sformatf("res_valid len=%0d n=%0d", v.len, n), 64'(res_valid), 64'(exp_v));
      if (res_valid) pulses++;
      if (done) dones++;
      if (exp_v) begin
        check($sformatf("res_idx n=%0d", n), 64'(res_idx), 64'(sb_q[0].idx));
        void'(sb_q.pop_front());
      end
      start   = (n == 0) || (n == v.dup_n);
      cfg_len = (n == 0) ? 8'(v.len) : ((n == v.dup_n) ? 8'(v.dup_len) : 8'($urandom));
      abort   = (n == v.abort_n);
      if (n == 0) begin
        for (int k = 0; k < v.len; k++) sb_q.push_back('{k, k + 22});
      end
      if (n == kill_n) begin
        while (sb_q.size() > 0 && sb_q[$].cyc > n) void'(sb_q.pop_back());
      end
      if (n == v.rst_n) begin
        rst = 1'b0;
        #1;
        check("rst_async_outs", 64'(dut_outs), 64'd0);
        check("rst_async_res", 64'(res_valid), 64'd0);
      end
      if (v.rst_n >= 0 && n == v.rst_n + 2) rst = 1'b1;
    end
    start = 1'b0;
    abort = 1'b0;
    check($sformatf("res_count len=%0d", v.len), 64'(pulses), 64'(v.n_res));
    check($sformatf("done_count len=%0d", v.len), 64'(dones), (v.done_at >= 0) ? 64'd1 : 64'd0);
    check("sb_empty", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    //           len dup dupl abort rst done_at n_res
    tbl[0] = '{3,   -1, 0,  -1,   -1, 25,   3};
    tbl[1] = '{0,   -1, 0,  -1,   -1, 17,   0};
    tbl[2] = '{3,   10, 9,  -1,   -1, 25,   3};
    tbl[3] = '{3,   -1, 0,  19,   -1, -1,   0};
    tbl[4] = '{3,   -1, 0,  -1,   -1, 25,   3};
    tbl[5] = '{7,   -1, 0,   5,   -1, -1,   0};
    tbl[6] = '{3,   -1, 0,  -1,   18, -1,   0};
    tbl[7] = '{3,   -1, 0,  -1,   -1, 25,   3};
    tbl[8] = '{1,   -1, 0,  -1,   -1, 23,   1};
    tbl[9] = '{255, -1, 0,  -1,   -1, 277,  255};

    rst = 1'b0; start = 1'b0; abort = 1'b0; cfg_len = 8'd0;
    repeat (2) @(negedge clk);
    check("reset_outs", 64'(dut_outs), 64'd0);
    check("reset_res", 64'({res_valid, res_idx}), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_outs", 64'(dut_outs), 64'd0);

    // start together with abort in IDLE must be ignored
    start = 1'b1; abort = 1'b1; cfg_len = 8'd4;
    @(negedge clk);
    check("start_with_abort_busy", 64'(busy), 64'd0);
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("start_with_abort_outs", 64'(dut_outs), 64'd0);

    for (int i = 0; i < 10; i++) run_vec(tbl[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
